fu_arbiter: RTL and testbench
=============================

Name: fu_arbiter

Overview:
- Shares one combinational FU (ALU + shifter + output mux) between two requesters, for example a decode/execute path and a branch/address path.
- Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin.
- Drives the FU operand and control buses from registers, captures the FU result and flags, and returns them with the requester ID on a valid/ready response channel.

Parameters:
- SIZE, 32, datapath width; must match the FU's size.
- SHW, $clog2(SIZE), shift-amount width.
- OPW, 9+SHW, width of the packed op word {G_select[3:0], H_select[1:0], shamnt[SHW-1:0], MF_select, I_R, I_L}, MSB first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  request valid, one bit per requester (bit i = requester i).
- req_ready  out  2  request accepted; the handshake completes on valid&ready.
- req0_a, req0_b  in  SIZE each  requester 0 operands A and B.
- req0_op  in  OPW  requester 0 packed op word.
- req1_a, req1_b, req1_op  in  SIZE, SIZE, OPW  requester 1 equivalents.
- fu_a, fu_b  out  SIZE each  registered operands to the FU.
- fu_op  out  OPW  registered packed op word to the FU.
- fu_f  in  SIZE  FU result F.
- fu_flags  in  4  FU flags {V,C,N,Z}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  SIZE  captured F.
- rsp_flags  out  4  captured {V,C,N,Z}.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- FSM states are IDLE, EXEC and RESP. Reset drives:
  - state to IDLE;
  - fu_a, fu_b, fu_op, rsp_data and rsp_flags to 0;
  - rsp_valid, rsp_id and busy to 0;
  - the round-robin pointer last_gnt to 1, so requester 0 wins the first tie.
- IDLE:
  - req_ready is combinational: only requester 0 valid → 2'b01; only requester 1 valid → 2'b10.
  - Both valid → the requester that is not last_gnt gets ready.
  - req_ready is 0 in every state other than IDLE.
  - On a handshake, latch the winner's a, b and op into fu_a, fu_b and fu_op; latch its ID; set last_gnt to the winner; go to EXEC.
- EXEC: lasts exactly one cycle, with the FU inputs stable from registers. At the end of the cycle, capture fu_f into rsp_data and fu_flags into rsp_flags, set rsp_valid=1, and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_data and rsp_flags until rsp_valid&rsp_ready.
  - On that handshake, clear rsp_valid and go to IDLE.
  - The next request can be accepted no earlier than the cycle after the response handshake; there is no bypass.
- Latency: request handshake in cycle N → rsp_valid high from cycle N+2. Throughput is at most one op per 3 cycles when rsp_ready is held high.
- fu_a, fu_b and fu_op change only on a request handshake and hold their values in EXEC, RESP and IDLE.
- Requesters must hold valid and payload stable until ready. A valid that deasserts without ready is legal and is simply not served; no grant is stored.
- Arbitration is evaluated only in IDLE. Requests that arrive during EXEC or RESP wait.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- The FU is combinational and never stalls; flags are not interpreted, only passed through.
- Reset asserted in any state aborts the op:
  - no response is produced;
  - rsp_valid falls on the next edge;
  - the pointer returns to its reset value.
- busy = (state != IDLE).

Test Plan:
Bench FU stub: fu_f = fu_a ^ fu_b; fu_flags = fu_op[3:0].
- Single op: after reset, req0 valid, a=0x5, b=0x3, op=0x00A; rsp_ready=1 → req_ready=01 in cycle 0; fu_a=0x5 and fu_b=0x3 in cycle 1; rsp_valid in cycle 2 with rsp_id=0, rsp_data=0x6, rsp_flags=0xA; busy=0 in cycle 3.
- Tie from reset: both valid, req1 a=0xF0, b=0x0F → first grant to 0 and second grant to 1, with responses in order id 0 then id 1 and the second rsp_data=0xFF. With both held valid for 4 ops, grants are 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_data and rsp_id stay stable and req_ready=00 throughout. Raising rsp_ready completes the handshake, and the next grant occurs one cycle later.
- Late arrival: req1 asserts during EXEC of a req0 op → req1 is not acknowledged until IDLE; then req_ready=10.
- Reset mid-op: assert rst for one cycle during EXEC or RESP → rsp_valid=0 and fu_a, fu_b, fu_op=0 after the edge. No response is produced, and the next tie goes to requester 0.
- Max values: a=0xFFFFFFFF, b=0 → rsp_data=0xFFFFFFFF; the op word with all bits set passes through to fu_op intact.

Source files
------------

// File: rtl/fu_arbiter.sv
// Round-robin arbiter sharing one combinational FU between two requesters.
// Each op is accepted in IDLE, runs for one EXEC cycle and is returned on a response channel.
module fu_arbiter #(
    parameter int SIZE = 32,
    parameter int SHW  = $clog2(SIZE),
    parameter int OPW  = 9 + SHW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic [OPW-1:0]  req0_op,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    input  logic [OPW-1:0]  req1_op,
    output logic [SIZE-1:0] fu_a,
    output logic [SIZE-1:0] fu_b,
    output logic [OPW-1:0]  fu_op,
    input  logic [SIZE-1:0] fu_f,
    input  logic [3:0]      fu_flags,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [SIZE-1:0] rsp_data,
    output logic [3:0]      rsp_flags,
    output logic            busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [SIZE-1:0] fu_a_q, fu_a_d;
    logic [SIZE-1:0] fu_b_q, fu_b_d;
    logic [OPW-1:0]  fu_op_q, fu_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [SIZE-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic            gnt_id;
    logic            req_hs;

    // On a tie, the requester that did not win last time gets ready.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_gnt_q ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign gnt_id = req_ready[1];
    assign req_hs = |(req_valid & req_ready);

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        fu_op_d     = fu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    state_d    = EXEC;
                    last_gnt_d = gnt_id;
                    rsp_id_d   = gnt_id;
                    fu_a_d     = gnt_id ? req1_a : req0_a;
                    fu_b_d     = gnt_id ? req1_b : req0_b;
                    fu_op_d    = gnt_id ? req1_op : req0_op;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_data_d  = fu_f;
                rsp_flags_d = fu_flags;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            fu_op_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            fu_op_q     <= fu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign fu_a      = fu_a_q;
    assign fu_b      = fu_b_q;
    assign fu_op     = fu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fu_arbiter.sv
// Bench for fu_arbiter: directed requests, expected responses queued and checked by a monitor.
module tb_fu_arbiter;

    localparam int SIZE = 32;
    localparam int OPW  = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [SIZE-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]  req0_op, req1_op;
    logic [SIZE-1:0] fu_a, fu_b, fu_f;
    logic [OPW-1:0]  fu_op;
    logic [3:0]      fu_flags;
    logic            rsp_valid, rsp_ready, rsp_id, busy;
    logic [SIZE-1:0] rsp_data;
    logic [3:0]      rsp_flags;

    typedef struct packed {
        logic            id;
        logic [SIZE-1:0] data;
        logic [3:0]      flags;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // FU stub
    assign fu_f     = fu_a ^ fu_b;
    assign fu_flags = fu_op[3:0];

    fu_arbiter #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_op     (fu_op),
        .fu_f      (fu_f),
        .fu_flags  (fu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [SIZE-1:0] data, input logic [3:0] flags);
        rsp_t e;
        e.id    = id;
        e.data  = data;
        e.flags = flags;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for an IDLE grant, checks which requester got ready, then steps past the edge.
    task automatic grant(input logic [1:0] exp, input string name);
        int n = 0;
        @(negedge clk);
        while ((req_ready & req_valid) == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(req_ready), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops one expected entry per response handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d data %0h, required no response",
                             rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fu_a", 64'(fu_a), 64'd0);
        chk("rst_fu_op", 64'(fu_op), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;

        // Single op
        req0_a = 32'h5; req0_b = 32'h3; req0_op = 14'h00A;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        push(1'b0, 32'h6, 4'hA);
        grant(2'b01, "single_ready");
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_fu_a", 64'(fu_a), 64'h5);
        chk("single_fu_b", 64'(fu_b), 64'h3);
        chk("single_exec_busy", 64'(busy), 64'd1);
        chk("single_exec_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        chk("single_busy_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        drain("single_drain");

        // Tie from reset, both held valid for four ops
        do_reset();
        req0_a = 32'h1;  req0_b = 32'h2;  req0_op = 14'h003;
        req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 14'h005;
        req_valid = 2'b11;
        push(1'b0, 32'h3, 4'h3);
        grant(2'b01, "tie_g0");
        push(1'b1, 32'hFF, 4'h5);
        grant(2'b10, "tie_g1");
        push(1'b0, 32'h3, 4'h3);
        grant(2'b01, "tie_g2");
        push(1'b1, 32'hFF, 4'h5);
        grant(2'b10, "tie_g3");
        req_valid = 2'b00;
        drain("tie_drain");

        // Backpressure, with requester 1 waiting throughout
        rsp_ready = 1'b0;
        req0_a = 32'hAA; req0_b = 32'h55; req0_op = 14'h007;
        req1_a = 32'h100; req1_b = 32'h001; req1_op = 14'h00C;
        req_valid = 2'b01;
        push(1'b0, 32'hFF, 4'h7);
        grant(2'b01, "bp_g0");
        req_valid = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_data", 64'(rsp_data), 64'hFF);
            chk("bp_rsp_id", 64'(rsp_id), 64'd0);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("bp_next_grant", 64'(req_ready), 64'b10);
        push(1'b1, 32'h101, 4'hC);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain("bp_drain");

        // Late arrival of requester 1 during EXEC
        req0_a = 32'h3; req0_b = 32'h3; req0_op = 14'h001;
        req1_a = 32'h0; req1_b = 32'h7; req1_op = 14'h00E;
        req_valid = 2'b01;
        push(1'b0, 32'h0, 4'h1);
        grant(2'b01, "late_g0");
        req_valid = 2'b10;
        @(negedge clk);
        chk("late_exec_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("late_resp_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        push(1'b1, 32'h7, 4'hE);
        grant(2'b10, "late_g1");
        req_valid = 2'b00;
        drain("late_drain");

        // Reset during EXEC aborts the op and restores the pointer
        rsp_ready = 1'b0;
        req0_a = 32'h77; req0_b = 32'h11; req0_op = 14'h0F0;
        req_valid = 2'b01;
        grant(2'b01, "abort_g0");
        req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_fu_a", 64'(fu_a), 64'd0);
        chk("abort_fu_b", 64'(fu_b), 64'd0);
        chk("abort_fu_op", 64'(fu_op), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        req0_a = 32'h9; req0_b = 32'h1; req0_op = 14'h002;
        req1_a = 32'h4; req1_b = 32'h4; req1_op = 14'h004;
        req_valid = 2'b11;
        push(1'b0, 32'h8, 4'h2);
        grant(2'b01, "abort_tie");
        req_valid = 2'b00;
        drain("abort_drain");

        // Max values
        req1_a = 32'hFFFF_FFFF; req1_b = 32'h0; req1_op = 14'h3FFF;
        req_valid = 2'b10;
        push(1'b1, 32'hFFFF_FFFF, 4'hF);
        grant(2'b10, "max_g");
        req_valid = 2'b00;
        @(negedge clk);
        chk("max_fu_op", 64'(fu_op), 64'h3FFF);
        chk("max_fu_a", 64'(fu_a), 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        drain("max_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
